// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int LINE_W     = 256;  // bits per cache line / memory beat
  localparam int OFFSET_W   = 5;    // byte offset bits within a line
  localparam int WORD_SEL_W = 3;    // 32-bit word select within a line

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_FILL      = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write,
// full-line fill or single-word store into the addressed line.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX   = $clog2(LINES),
  parameter int TAG_W = 32 - OFFSET_W - IDX
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX-1:0]        idx_i,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [LINE_W-1:0]     rd_line_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_W-1:0]     line_data_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [31:0]           word_data_i
);

  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;

  assign rd_tag_o   = r_tag[idx_i];
  assign rd_line_o  = r_data[idx_i];
  assign rd_valid_o = r_valid[idx_i];
  assign rd_dirty_o = r_dirty[idx_i];

  // Line state bits: a fill validates and cleans, a store dirties.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (line_we_i) begin
      r_valid[idx_i] <= 1'b1;
      r_dirty[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      r_dirty[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: written on fill or store hit.
  // NOTE: arrays have no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      r_tag[idx_i]  <= line_tag_i;
      r_data[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      r_data[idx_i][{word_sel_i, 5'b0} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller:
// hit detection, miss FSM (writeback, allocate, fill) and memory port muxing.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              Miss_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = 32 - OFFSET_W - IDX;
  localparam int LADDR_W = 32 - OFFSET_W;

  state_t             r_state, w_next;
  logic [LADDR_W-1:0] r_miss_line;   // line address of the miss being serviced

  logic [LADDR_W-1:0] w_req_line;
  logic [IDX-1:0]     w_idx;
  logic [TAG_W-1:0]   w_tag, w_rd_tag;
  logic [WORD_SEL_W-1:0] w_word;
  logic               w_valid, w_dirty, w_hit, w_miss, w_idle;
  logic [LINE_W-1:0]  w_line;
  logic               w_unused_addr;

  assign w_unused_addr = ^cpu_addr_i[1:0];

  // During a miss the latched address steers the arrays, so memory outputs
  // stay stable even if the CPU side changes.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_req_line = w_idle ? cpu_addr_i[31:OFFSET_W] : r_miss_line;
  assign w_idx      = w_req_line[IDX-1:0];
  assign w_tag      = w_req_line[LADDR_W-1:IDX];
  assign w_word     = cpu_addr_i[OFFSET_W-1:2];

  dcache_sram #(.LINES(LINES), .IDX(IDX), .TAG_W(TAG_W)) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (w_idx),
    .rd_tag_o    (w_rd_tag),
    .rd_valid_o  (w_valid),
    .rd_dirty_o  (w_dirty),
    .rd_line_o   (w_line),
    .line_we_i   ((r_state == ST_ALLOCATE) && mem_ack_i),
    .line_tag_i  (w_tag),
    .line_data_i (mem_data_i),
    .word_we_i   (w_hit && cpu_we_i),
    .word_sel_i  (w_word),
    .word_data_i (cpu_data_i)
  );

  assign w_hit  = rst_i && w_idle && cpu_req_i && w_valid && (w_rd_tag == w_tag);
  assign w_miss = w_idle && cpu_req_i && !w_hit;

  assign cpu_data_o   = w_hit ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign Miss_stall_o = rst_i && (w_miss || !w_idle);

  // FSM state and miss-address capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_miss_line <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_miss_line <= cpu_addr_i[31:OFFSET_W];
    end
  end

  // Next-state logic; acks outside WRITEBACK/ALLOCATE are ignored.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_miss) w_next = (w_valid && w_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
      ST_WRITEBACK: if (mem_ack_i) w_next = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem_ack_i) w_next = ST_FILL;
      ST_FILL:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Memory port: victim line on writeback, request line address on allocate.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = '0;
    case (r_state)
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {w_rd_tag, w_idx, {OFFSET_W{1'b0}}};
        mem_data_o   = w_line;
      end
      ST_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_req_line, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule
